// File: rtl/mem_io_responder_if.sv
`default_nettype none
// ============================================================================
// Module : mem_io_responder_if
// CPU byte-bus and UART stream signals between a bus master and the responder.
// Rev    : 1.0
// ============================================================================
interface mem_io_responder_if;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        program_done;
    logic        tx_overflow;

    modport master (
        output cpu_a, cpu_dout, cpu_wr, rx_data, rx_valid, tx_ready,
        input  cpu_din, io_buffer_full, rx_ready, tx_data, tx_valid,
               program_done, tx_overflow
    );

    modport slave (
        input  cpu_a, cpu_dout, cpu_wr, rx_data, rx_valid, tx_ready,
        output cpu_din, io_buffer_full, rx_ready, tx_data, tx_valid,
               program_done, tx_overflow
    );
endinterface
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module : mem_io_responder
// Byte-bus target: 128KB RAM plus UART FIFOs, cycle counter and stop flag.
// Rev    : 1.0
// ============================================================================
module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_responder_if.slave bus
);
    localparam int TX_PW       = $clog2(TX_DEPTH);
    localparam int RX_PW       = $clog2(RX_DEPTH);
    localparam int TX_NEAR_INT = TX_DEPTH - 1;
    localparam logic [TX_PW:0] TX_NEAR = TX_NEAR_INT[TX_PW:0];
    localparam logic [TX_PW:0] TX_ONE  = {{TX_PW{1'b0}}, 1'b1};
    localparam logic [RX_PW:0] RX_ONE  = {{RX_PW{1'b0}}, 1'b1};

    // ---------------- address decode ----------------
    logic [1:0]            region;
    logic [2:0]            io_off;
    logic                  is_ram;
    logic                  is_io;
    logic                  io_rd;
    logic                  io_wr;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  addr_unused;

    assign region      = bus.cpu_a[17:16];
    assign io_off      = bus.cpu_a[2:0];
    assign is_ram      = ~region[1];
    assign is_io       = &region;
    assign io_rd       = is_io & ~bus.cpu_wr;
    assign io_wr       = is_io &  bus.cpu_wr;
    assign ram_idx     = bus.cpu_a[RAM_ADDR_W-1:0];
    assign addr_unused = ^bus.cpu_a[31:18];

    // ---------------- RAM (no reset, synchronous read) ----------------
    logic [7:0] mem [2**RAM_ADDR_W];
    logic [7:0] ram_rd_q;

    always_ff @(posedge clk_in) begin
        if (bus.cpu_wr && is_ram) begin
            mem[ram_idx] <= bus.cpu_dout;
        end
        ram_rd_q <= mem[ram_idx];
    end

    // ---------------- state registers ----------------
    logic           sel_ram_q, sel_ram_d;
    logic [7:0]     io_din_q,  io_din_d;
    logic [31:0]    cnt_q,     cnt_d;
    logic [31:0]    snap_q,    snap_d;
    logic           done_q,    done_d;
    logic           ovf_q,     ovf_d;
    logic [TX_PW:0] tx_wr_q,   tx_wr_d;
    logic [TX_PW:0] tx_rd_q,   tx_rd_d;
    logic [RX_PW:0] rx_wr_q,   rx_wr_d;
    logic [RX_PW:0] rx_rd_q,   rx_rd_d;

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_PW:0] tx_count;
    logic           tx_empty;
    logic           tx_full;
    logic           tx_req;
    logic           tx_push;
    logic           tx_pop;
    logic [7:0]     tx_wdata;

    assign tx_count = tx_wr_q - tx_rd_q;
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = ((tx_wr_q ^ tx_rd_q) == {1'b1, {TX_PW{1'b0}}});
    assign tx_req   = io_wr && (((io_off == 3'd0) && (bus.cpu_dout != 8'h00)) ||
                                 (io_off == 3'd4));
    // Full is checked strictly, so a push into a full FIFO drops even with a pop.
    assign tx_push  = tx_req & ~tx_full;
    assign tx_pop   = ~tx_empty & bus.tx_ready;
    assign tx_wdata = (io_off == 3'd4) ? 8'h00 : bus.cpu_dout;

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wr_q[TX_PW-1:0]] <= tx_wdata;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic           rx_empty;
    logic           rx_full;
    logic           rx_push;
    logic           rx_pop;
    logic [7:0]     rx_head;

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = ((rx_wr_q ^ rx_rd_q) == {1'b1, {RX_PW{1'b0}}});
    assign rx_push  = bus.rx_valid & ~rx_full;
    assign rx_pop   = io_rd && (io_off == 3'd0) && !rx_empty;
    assign rx_head  = rx_mem[rx_rd_q[RX_PW-1:0]];

    always_ff @(posedge clk_in) begin
        if (rx_push) begin
            rx_mem[rx_wr_q[RX_PW-1:0]] <= bus.rx_data;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        sel_ram_d = 1'b0;
        io_din_d  = 8'h00;
        cnt_d     = cnt_q + 32'd1;
        snap_d    = snap_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        tx_wr_d   = tx_wr_q;
        tx_rd_d   = tx_rd_q;
        rx_wr_d   = rx_wr_q;
        rx_rd_d   = rx_rd_q;

        if (!bus.cpu_wr && is_ram) begin
            sel_ram_d = 1'b1;
        end

        if (io_rd) begin
            case (io_off)
                3'd0:    io_din_d = rx_empty ? 8'h00 : rx_head;
                3'd4: begin
                    io_din_d = cnt_q[7:0];
                    snap_d   = cnt_q;
                end
                3'd5:    io_din_d = snap_q[15:8];
                3'd6:    io_din_d = snap_q[23:16];
                3'd7:    io_din_d = snap_q[31:24];
                default: io_din_d = 8'h00;
            endcase
        end

        if (io_wr && (io_off == 3'd4)) done_d = 1'b1;
        if (tx_req && tx_full)         ovf_d  = 1'b1;
        if (tx_push) tx_wr_d = tx_wr_q + TX_ONE;
        if (tx_pop)  tx_rd_d = tx_rd_q + TX_ONE;
        if (rx_push) rx_wr_d = rx_wr_q + RX_ONE;
        if (rx_pop)  rx_rd_d = rx_rd_q + RX_ONE;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sel_ram_q <= 1'b0;
            io_din_q  <= 8'h00;
            cnt_q     <= 32'd0;
            snap_q    <= 32'd0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
        end else begin
            sel_ram_q <= sel_ram_d;
            io_din_q  <= io_din_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
        end
    end

    // ---------------- outputs ----------------
    // sel_ram_q resets low, so cpu_din clears asynchronously with the I/O register.
    assign bus.cpu_din        = sel_ram_q ? ram_rd_q : io_din_q;
    assign bus.io_buffer_full = (tx_count >= TX_NEAR);
    assign bus.rx_ready       = ~rx_full;
    assign bus.tx_data        = tx_mem[tx_rd_q[TX_PW-1:0]];
    assign bus.tx_valid       = ~tx_empty;
    assign bus.program_done   = done_q;
    assign bus.tx_overflow    = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_io_responder
// Directed scoreboard bench for mem_io_responder (RAM, UART FIFOs, counter).
// Rev    : 1.0
// ============================================================================
module tb_mem_io_responder;
    logic clk = 1'b0;
    logic rst_in;

    mem_io_responder_if bus ();

    mem_io_responder #(
        .RAM_ADDR_W (17),
        .TX_DEPTH   (8),
        .RX_DEPTH   (8)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_rd();
        rd_exp_t e;
        e = rd_q.pop_front();
        chk(e.tag, {24'h0, bus.cpu_din}, {24'h0, e.exp});
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        bus.cpu_a = a; bus.cpu_wr = 1'b0; bus.cpu_dout = 8'h00;
        rd_q.push_back('{tag, exp});
        @(posedge clk); #1;
        pop_rd();
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cpu_a = a; bus.cpu_wr = 1'b1; bus.cpu_dout = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.cpu_a = 32'h0002_0000; bus.cpu_wr = 1'b0; bus.cpu_dout = 8'h00;
            @(posedge clk); #1;
        end
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge clk);
        bus.cpu_a = 32'h0002_0000; bus.cpu_wr = 1'b0;
        bus.rx_valid = 1'b1; bus.rx_data = d;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && tx_q.size() != 0; i++) idle(1);
        chk(tag, tx_q.size(), 0);
    endtask

    task automatic forced_cnt_read(input logic [31:0] val, input logic [7:0] exp, input string tag);
        @(negedge clk);
        force dut.cnt_q = val;
        bus.cpu_a = 32'h0003_0004; bus.cpu_wr = 1'b0;
        rd_q.push_back('{tag, exp});
        #1 release dut.cnt_q;
        @(posedge clk); #1;
        pop_rd();
    endtask

    // TX stream scoreboard: a byte leaves when tx_valid && tx_ready at the edge.
    always @(negedge clk) begin
        #3;
        if (rst_in && bus.tx_valid && bus.tx_ready) begin
            if (tx_q.size() == 0) chk("tx_unexpected_valid", {31'h0, bus.tx_valid}, 32'h0);
            else                  chk("tx_data", {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in       = 1'b0;
        bus.cpu_a    = 32'h0002_0000;
        bus.cpu_wr   = 1'b0;
        bus.cpu_dout = 8'h00;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_din",      {24'h0, bus.cpu_din}, 32'h0);
        chk("rst_tx_valid",     {31'h0, bus.tx_valid}, 32'h0);
        chk("rst_rx_ready",     {31'h0, bus.rx_ready}, 32'h1);
        chk("rst_program_done", {31'h0, bus.program_done}, 32'h0);
        chk("rst_tx_overflow",  {31'h0, bus.tx_overflow}, 32'h0);
        chk("rst_io_full",      {31'h0, bus.io_buffer_full}, 32'h0);
        rst_in = 1'b1;

        // Counter starts at 0 on the first edge after reset and then increments.
        rd(32'h0003_0004, 8'h00, "cnt_first");
        rd(32'h0003_0004, 8'h01, "cnt_second");

        // RAM path
        wr(32'h0000_0010, 8'hA5);
        chk("wr_cycle_din", {24'h0, bus.cpu_din}, 32'h0);
        rd(32'h0000_0010, 8'hA5, "ram_rd");
        wr(32'h0001_FFFF, 8'h3C);
        rd(32'h0001_FFFF, 8'h3C, "ram_top");
        wr(32'h0002_0010, 8'h77);
        rd(32'h0002_0010, 8'h00, "unmapped_rd");
        rd(32'h0000_0010, 8'hA5, "ram_no_alias");

        // UART out
        tx_q.push_back(8'h48);
        wr(32'h0003_0000, 8'h48);
        wr(32'h0003_0000, 8'h00);
        wr(32'h0003_0001, 8'h55);
        tx_q.push_back(8'h69);
        wr(32'h0003_0000, 8'h69);
        drain("tx_stream_left");
        tx_q.push_back(8'h00);
        wr(32'h0003_0004, 8'h01);
        chk("program_done_set", {31'h0, bus.program_done}, 32'h1);
        drain("tx_done_byte_left");

        // TX backpressure and overflow
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tx_q.push_back(8'h10 + i[7:0]);
            wr(32'h0003_0000, 8'h10 + i[7:0]);
            if (i == 5) chk("near_full_after_6", {31'h0, bus.io_buffer_full}, 32'h0);
            if (i == 6) chk("near_full_after_7", {31'h0, bus.io_buffer_full}, 32'h1);
        end
        chk("no_ovf_at_8", {31'h0, bus.tx_overflow}, 32'h0);
        @(negedge clk);
        bus.tx_ready = 1'b1;
        bus.cpu_a = 32'h0003_0000; bus.cpu_wr = 1'b1; bus.cpu_dout = 8'hEE;
        @(posedge clk); #1;
        chk("ovf_on_full_push", {31'h0, bus.tx_overflow}, 32'h1);
        drain("tx_backpressure_left");
        idle(1);
        chk("tx_empty_after_drain", {31'h0, bus.tx_valid}, 32'h0);
        chk("near_full_cleared",    {31'h0, bus.io_buffer_full}, 32'h0);

        // UART in
        rx_push(8'h31);
        rx_push(8'h32);
        rd(32'h0003_0000, 8'h31, "rx_first");
        rd(32'h0003_0000, 8'h32, "rx_second");
        rd(32'h0003_0000, 8'h00, "rx_empty_rd");
        @(negedge clk);
        bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
        bus.cpu_a = 32'h0003_0000; bus.cpu_wr = 1'b0;
        rd_q.push_back('{"rx_push_pop_empty", 8'h00});
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        pop_rd();
        rd(32'h0003_0000, 8'h5A, "rx_kept");
        for (int i = 0; i < 8; i++) rx_push(8'h40 + i[7:0]);
        chk("rx_full_not_ready", {31'h0, bus.rx_ready}, 32'h0);
        rx_push(8'h99);
        for (int i = 0; i < 8; i++) rd(32'h0003_0000, 8'h40 + i[7:0], "rx_fifo_order");
        rd(32'h0003_0000, 8'h00, "rx_drained");
        chk("rx_ready_again", {31'h0, bus.rx_ready}, 32'h1);

        // Counter snapshot coherence and wrap
        forced_cnt_read(32'h0000_01F3, 8'hF3, "cnt_lo");
        rd(32'h0003_0005, 8'h01, "snap_b1");
        rd(32'h0003_0006, 8'h00, "snap_b2");
        rd(32'h0003_0007, 8'h00, "snap_b3");
        forced_cnt_read(32'hFFFF_FFFF, 8'hFF, "cnt_max");
        rd(32'h0003_0004, 8'h00, "cnt_wrapped");
        rd(32'h0003_0007, 8'h00, "snap_wrapped_b3");

        // Asynchronous reset mid-traffic
        bus.tx_ready = 1'b0;
        wr(32'h0003_0004, 8'h01);
        wr(32'h0003_0000, 8'h11);
        wr(32'h0003_0000, 8'h22);
        rd(32'h0000_0010, 8'hA5, "pre_reset_din");
        chk("pre_reset_tx_valid", {31'h0, bus.tx_valid}, 32'h1);
        chk("pre_reset_done",     {31'h0, bus.program_done}, 32'h1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("async_rst_cpu_din",  {24'h0, bus.cpu_din}, 32'h0);
        chk("async_rst_done",     {31'h0, bus.program_done}, 32'h0);
        chk("async_rst_ovf",      {31'h0, bus.tx_overflow}, 32'h0);
        chk("async_rst_rx_ready", {31'h0, bus.rx_ready}, 32'h1);
        @(posedge clk); #1;
        rst_in = 1'b1;
        bus.tx_ready = 1'b1;
        rd(32'h0003_0004, 8'h00, "cnt_after_rst");
        rd(32'h0000_0010, 8'hA5, "ram_kept_over_rst");
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
